mac_cmd_master: RTL and testbench

MAC_CMD_MASTER -- requirements
Module: mac_cmd_master

---
 rtl/mac_cmd_master.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mac_cmd_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_cmd_master.sv
`default_nettype none
// ============================================================================
// Module : mac_cmd_master
// Brief  : AXI4-Lite master that runs one MAC command per request: writes A,
//          B and CTRL, polls STATUS, reads ACC back and returns a response.
// Rev    : 1.0
// ============================================================================
module mac_cmd_master #(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAC        = 8,
    parameter int POLL_LIMIT = 255
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [MAC-1:0]        cmd_a,
    input  logic [MAC-1:0]        cmd_b,
    input  logic                  cmd_clear,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_acc,
    output logic                  rsp_err,
    output logic [ADDRESS-1:0]    M_AWADDR,
    output logic                  M_AWVALID,
    input  logic                  M_AWREADY,
    output logic [DATA_WIDTH-1:0] M_WDATA,
    output logic [3:0]            M_WSTRB,
    output logic                  M_WVALID,
    input  logic                  M_WREADY,
    input  logic [1:0]            M_BRESP,
    input  logic                  M_BVALID,
    output logic                  M_BREADY,
    output logic [ADDRESS-1:0]    M_ARADDR,
    output logic                  M_ARVALID,
    input  logic                  M_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_RDATA,
    input  logic [1:0]            M_RRESP,
    input  logic                  M_RVALID,
    output logic                  M_RREADY
);
    localparam logic [ADDRESS-1:0] IDX_CTRL   = ADDRESS'(0);
    localparam logic [ADDRESS-1:0] IDX_A      = ADDRESS'(1);
    localparam logic [ADDRESS-1:0] IDX_B      = ADDRESS'(2);
    localparam logic [ADDRESS-1:0] IDX_ACC    = ADDRESS'(3);
    localparam logic [ADDRESS-1:0] IDX_STATUS = ADDRESS'(4);
    localparam logic [8:0]         POLL_MAX   = 9'(POLL_LIMIT);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        WR_A    = 4'd1,
        WR_B    = 4'd2,
        WR_CTRL = 4'd3,
        POLL_AR = 4'd4,
        POLL_R  = 4'd5,
        RD_AR   = 4'd6,
        RD_R    = 4'd7,
        RESP    = 4'd8
    } state_t;

    state_t                state_q, state_d;
    logic [MAC-1:0]        a_q, a_d, b_q, b_d;
    logic                  clr_q, clr_d;
    logic [8:0]            poll_cnt_q, poll_cnt_d;
    logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                  arvalid_q, arvalid_d, rready_q, rready_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [ADDRESS-1:0]    awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rsp_acc_q, rsp_acc_d;

    logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [8:0] poll_next;

    assign aw_hs     = awvalid_q & M_AWREADY;
    assign w_hs      = wvalid_q & M_WREADY;
    assign b_hs      = bready_q & M_BVALID;
    assign ar_hs     = arvalid_q & M_ARREADY;
    assign r_hs      = rready_q & M_RVALID;
    assign poll_next = poll_cnt_q + 9'd1;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        clr_d       = clr_q;
        poll_cnt_d  = poll_cnt_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_acc_d   = rsp_acc_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    a_d         = cmd_a;
                    b_d         = cmd_b;
                    clr_d       = cmd_clear;
                    cmd_ready_d = 1'b0;
                    state_d     = WR_A;
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    awaddr_d    = IDX_A;
                    wdata_d     = DATA_WIDTH'(cmd_a);
                end
            end
            WR_A, WR_B, WR_CTRL: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // BREADY is registered, so it rises the cycle after the later of the two handshakes.
                bready_d = aw_done_d & w_done_d;
                if (b_hs) begin
                    bready_d = 1'b0;
                    if (M_BRESP != 2'b00) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_acc_d   = '0;
                    end else if (state_q == WR_CTRL) begin
                        state_d   = POLL_AR;
                        arvalid_d = 1'b1;
                        araddr_d  = IDX_STATUS;
                    end else begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        if (state_q == WR_A) begin
                            state_d  = WR_B;
                            awaddr_d = IDX_B;
                            wdata_d  = DATA_WIDTH'(b_q);
                        end else begin
                            state_d    = WR_CTRL;
                            awaddr_d   = IDX_CTRL;
                            wdata_d    = DATA_WIDTH'({clr_q, 1'b1});
                            poll_cnt_d = 9'd0;
                        end
                    end
                end
            end
            POLL_AR, RD_AR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = (state_q == POLL_AR) ? POLL_R : RD_R;
                end
            end
            POLL_R: begin
                if (r_hs) begin
                    rready_d   = 1'b0;
                    poll_cnt_d = poll_next;
                    if (M_RRESP != 2'b00 || (!M_RDATA[0] && poll_next >= POLL_MAX)) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_acc_d   = '0;
                    end else begin
                        state_d   = M_RDATA[0] ? RD_AR : POLL_AR;
                        arvalid_d = 1'b1;
                        araddr_d  = M_RDATA[0] ? IDX_ACC : IDX_STATUS;
                    end
                end
            end
            RD_R: begin
                if (r_hs) begin
                    rready_d    = 1'b0;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (M_RRESP != 2'b00);
                    rsp_acc_d   = (M_RRESP != 2'b00) ? '0 : M_RDATA;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            clr_q       <= 1'b0;
            poll_cnt_q  <= 9'd0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_acc_q   <= '0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            clr_q       <= clr_d;
            poll_cnt_q  <= poll_cnt_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_acc_q   <= rsp_acc_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_acc   = rsp_acc_q;
    assign rsp_err   = rsp_err_q;
    assign M_AWADDR  = awaddr_q;
    assign M_AWVALID = awvalid_q;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = 4'hF;
    assign M_WVALID  = wvalid_q;
    assign M_BREADY  = bready_q;
    assign M_ARADDR  = araddr_q;
    assign M_ARVALID = arvalid_q;
    assign M_RREADY  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_cmd_master.sv
`default_nettype none
// ============================================================================
// Module : tb_mac_cmd_master
// Brief  : Directed bench for mac_cmd_master against a behavioural MAC slave.
// Rev    : 1.0
// ============================================================================
module tb_mac_cmd_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 8;
    localparam int PL = 4;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_clear;
    logic [MW-1:0] cmd_a, cmd_b;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_acc;
    logic [AW-1:0] M_AWADDR, M_ARADDR;
    logic          M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
    logic [DW-1:0] M_WDATA, M_RDATA;
    logic [3:0]    M_WSTRB;
    logic [1:0]    M_BRESP, M_RRESP;
    logic          M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

    always #5 ACLK = ~ACLK;

    mac_cmd_master #(.ADDRESS(AW), .DATA_WIDTH(DW), .MAC(MW), .POLL_LIMIT(PL)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_clear(cmd_clear),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_acc(rsp_acc), .rsp_err(rsp_err),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    int total = 0;
    int bad   = 0;

    // Slave knobs, driven by the stimulus block
    int          aw_delay = 0;
    int          w_delay = 0;
    int          status_delay = 1;
    logic        status_never = 1'b0;
    logic [31:0] err_idx = 32'hFFFF_FFFF;

    // Slave state
    int          aw_cnt, w_cnt;
    logic        aw_got, w_got;
    logic [31:0] aw_idx, w_data;
    logic [31:0] reg_a = 0, reg_b = 0, reg_ctrl = 0, reg_acc = 0;
    int          busy = 0;
    int          status_reads = 0, ctrl_writes = 0, aw_total = 0, overlap = 0;
    logic [31:0] aw_log [0:255];

    assign M_AWREADY = (aw_cnt >= aw_delay);
    assign M_WREADY  = (w_cnt >= w_delay);
    assign M_ARREADY = 1'b1;
    assign M_RRESP   = 2'b00;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            aw_idx <= 0; w_data <= 0;
            M_BVALID <= 1'b0; M_BRESP <= 2'b00; M_RVALID <= 1'b0; M_RDATA <= 0;
        end else begin
            if (M_AWVALID && M_AWREADY) begin
                aw_got <= 1'b1; aw_idx <= M_AWADDR; aw_cnt <= 0;
                aw_log[aw_total[7:0]] <= M_AWADDR;
                aw_total <= aw_total + 1;
            end else if (M_AWVALID) aw_cnt <= aw_cnt + 1;
            if (M_WVALID && M_WREADY) begin
                w_got <= 1'b1; w_data <= M_WDATA; w_cnt <= 0;
            end else if (M_WVALID) w_cnt <= w_cnt + 1;
            if (M_BVALID && M_BREADY) M_BVALID <= 1'b0;
            else if (aw_got && w_got) begin
                aw_got <= 1'b0; w_got <= 1'b0; M_BVALID <= 1'b1;
                if (aw_idx == err_idx) M_BRESP <= 2'b10;
                else begin
                    M_BRESP <= 2'b00;
                    case (aw_idx)
                        0: begin
                            reg_ctrl <= w_data;
                            ctrl_writes <= ctrl_writes + 1;
                            if (w_data[0]) begin
                                busy <= status_delay;
                                reg_acc <= w_data[1] ? reg_a * reg_b : reg_acc + reg_a * reg_b;
                            end
                        end
                        1: reg_a <= w_data;
                        2: reg_b <= w_data;
                        default: ;
                    endcase
                end
            end
            if (M_RVALID && M_RREADY) M_RVALID <= 1'b0;
            else if (M_ARVALID && !M_RVALID) begin
                M_RVALID <= 1'b1;
                case (M_ARADDR)
                    4: begin
                        status_reads <= status_reads + 1;
                        if (status_never) M_RDATA <= 0;
                        else if (busy > 0) begin busy <= busy - 1; M_RDATA <= 0; end
                        else M_RDATA <= 1;
                    end
                    3: M_RDATA <= reg_acc;
                    2: M_RDATA <= reg_b;
                    1: M_RDATA <= reg_a;
                    0: M_RDATA <= reg_ctrl;
                    default: M_RDATA <= 0;
                endcase
            end
        end
    end

    always @(posedge ACLK)
        if (ARESETN && (M_AWVALID || M_WVALID || M_BREADY) && (M_ARVALID || M_RREADY))
            overlap <= overlap + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic clr);
        int n = 0;
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_clear = clr;
        while (!cmd_ready && n < 50) begin @(negedge ACLK); n++; end
        chk("cmd_accept", 32'(cmd_ready), 32'd1);
        @(negedge ACLK);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [31:0] exp_acc, input logic exp_err);
        int n = 0;
        while (!rsp_valid && n < 400) begin @(negedge ACLK); n++; end
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_acc"}, rsp_acc, exp_acc);
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
        chk({tag, "_release"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int s, sr, cw, na, nw, early, n, stable;
        logic [31:0] held;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_clear = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge ACLK);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_awvalid", 32'(M_AWVALID), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_wstrb", 32'(M_WSTRB), 32'hF);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Basic command with clear: 3*4
        s = aw_total; sr = status_reads;
        send_cmd(8'd3, 8'd4, 1'b1);
        wait_rsp("t1", 32'd12, 1'b0);
        chk("t1_reg_a", reg_a, 32'd3);
        chk("t1_reg_b", reg_b, 32'd4);
        chk("t1_reg_ctrl", reg_ctrl, 32'd3);
        chk("t1_aw0", aw_log[8'(s)], 32'd1);
        chk("t1_aw1", aw_log[8'(s + 1)], 32'd2);
        chk("t1_aw2", aw_log[8'(s + 2)], 32'd0);
        chk("t1_polls", 32'(status_reads - sr), 32'd2);

        // Accumulate, then clear again
        send_cmd(8'd2, 8'd5, 1'b0);
        wait_rsp("t2", 32'd22, 1'b0);
        chk("t2_reg_ctrl", reg_ctrl, 32'd1);
        send_cmd(8'd1, 8'd1, 1'b1);
        wait_rsp("t2b", 32'd1, 1'b0);

        // AWREADY delayed three cycles, WREADY immediate
        aw_delay = 3;
        send_cmd(8'd5, 8'd6, 1'b1);
        na = 0; nw = 0; early = 0;
        while (M_AWVALID && na < 20) begin
            na++;
            if (M_WVALID) nw++;
            if (M_BREADY) early++;
            @(negedge ACLK);
        end
        chk("t3_awvalid_cycles", 32'(na), 32'd4);
        chk("t3_wvalid_cycles", 32'(nw), 32'd1);
        chk("t3_bready_early", 32'(early), 32'd0);
        chk("t3_bready_after", 32'(M_BREADY), 32'd1);
        wait_rsp("t3", 32'd30, 1'b0);
        aw_delay = 0;

        // STATUS never completes: poll limit reached
        status_never = 1'b1; sr = status_reads;
        send_cmd(8'd2, 8'd2, 1'b0);
        wait_rsp("t4", 32'd0, 1'b1);
        chk("t4_polls", 32'(status_reads - sr), 32'd4);
        status_never = 1'b0;

        // Error response on the B write aborts before CTRL
        err_idx = 32'd2; cw = ctrl_writes; s = aw_total;
        send_cmd(8'd7, 8'd7, 1'b0);
        wait_rsp("t5", 32'd0, 1'b1);
        chk("t5_ctrl_writes", 32'(ctrl_writes - cw), 32'd0);
        chk("t5_aw_count", 32'(aw_total - s), 32'd2);
        err_idx = 32'hFFFF_FFFF;

        // Response back-pressure: held stable for 10 cycles
        send_cmd(8'd3, 8'd3, 1'b1);
        n = 0;
        while (!rsp_valid && n < 400) begin @(negedge ACLK); n++; end
        held = rsp_acc; stable = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            if (!rsp_valid || rsp_acc !== held) stable = 0;
        end
        chk("t6_stable", 32'(stable), 32'd1);
        wait_rsp("t6", 32'd9, 1'b0);

        // Reset while polling STATUS
        status_delay = 50;
        send_cmd(8'd4, 8'd4, 1'b1);
        n = 0;
        while (!M_RREADY && n < 100) begin @(negedge ACLK); n++; end
        chk("t7_in_poll", 32'(M_RREADY), 32'd1);
        ARESETN = 1'b0;
        #1;
        chk("t7_rready", 32'(M_RREADY), 32'd0);
        chk("t7_araddr", M_ARADDR, 32'd0);
        chk("t7_wdata", M_WDATA, 32'd0);
        chk("t7_rsp_acc", rsp_acc, 32'd0);
        chk("t7_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("t7_wstrb", 32'(M_WSTRB), 32'hF);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("t7_cmd_ready_rel", 32'(cmd_ready), 32'd1);
        status_delay = 1; s = aw_total;
        send_cmd(8'd4, 8'd4, 1'b1);
        wait_rsp("t8", 32'd16, 1'b0);
        chk("t8_first_aw", aw_log[8'(s)], 32'd1);

        chk("no_overlap", 32'(overlap), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
